// File: rtl/gsm_pkg.sv
// Shared definitions for the GSM modem command scheduler: FSM state
// encoding, ASCII constants, the AT-command script ROM and its entry layout.
package gsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEND   = 3'd2,
    ST_TXWAIT = 3'd3,
    ST_GAP    = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] QUOTE = 8'h22;
  localparam logic [7:0] CTRLZ = 8'h1A;

  // ROM entry layout: {eos, eoc, byte}. eos always comes with eoc.
  localparam int ROM_W    = 10;
  localparam int EOS_BIT  = 9;
  localparam int EOC_BIT  = 8;
  localparam int BYTE_MSB = 7;

  localparam int SCRIPT_LEN = 8;
  localparam int SCRIPT_IW  = 3;
  localparam int CALL_BASE  = 0;
  localparam int SMS_BASE   = 3;

  // Call script: "AT\r" (eos on CR).
  // SMS script:  "AT\r" (eoc on CR), then "X" and Ctrl-Z (eos on Ctrl-Z).
  localparam logic [ROM_W-1:0] SCRIPT_ROM [SCRIPT_LEN] = '{
    {2'b00, 8'h41},
    {2'b00, 8'h54},
    {2'b11, CR},
    {2'b00, 8'h41},
    {2'b00, 8'h54},
    {2'b01, CR},
    {2'b00, 8'h58},
    {2'b11, CTRLZ}
  };

endpackage

// File: rtl/uart_tx_byte.sv
// Byte-level 8N1 UART transmitter. Accepts a byte when idle (tx_ready high),
// sends start bit, 8 data bits LSB first and stop bit, each CLKS_PER_BIT
// cycles long. tx_done pulses during the last cycle of the stop bit.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 2500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       line_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          busy_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    shift_q;
  logic          line_q;

  // Frame sequencer: bit_q 0 = start, 1..8 = data, 9 = stop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      bit_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
    end else if (!busy_q) begin
      if (tx_valid) begin
        busy_q  <= 1'b1;
        bit_q   <= '0;
        cnt_q   <= '0;
        shift_q <= tx_data;
        line_q  <= 1'b0;
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        line_q <= 1'b1;
      end else begin
        bit_q <= bit_q + 4'd1;
        if (bit_q == 4'd8) begin
          line_q <= 1'b1;
        end else begin
          line_q  <= shift_q[0];
          shift_q <= {1'b0, shift_q[7:1]};
        end
      end
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tx_ready = !busy_q;
  assign tx_done  = busy_q && (bit_q == 4'd9) && (cnt_q == CNT_LAST);
  assign line_tx  = line_q;

endmodule

// File: rtl/gsm_cmd_sched.sv
// GSM modem command scheduler. Arbitrates between the call (0) and SMS (1)
// requesters, streams the winner's AT script from the ROM through the UART
// and keeps the line idle for GAP_CYCLES after each command terminator.
// Build option GSM_SCHED_RR_EN: round-robin on simultaneous requests;
// without it, SMS (requester 1) has fixed priority.
//
// Handshake with the UART: tx_valid is raised only in SEND and holds the
// byte stable; a byte transfers on a clock edge where tx_valid and tx_ready
// are both high, and tx_valid drops the cycle after.
module gsm_cmd_sched
  import gsm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2500,
  parameter int GAP_CYCLES   = 12_000_000,
  parameter int ROM_AW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       busy,
  output logic       line_tx
);

  localparam int GW = $clog2(GAP_CYCLES);
  // LOAD and SEND add two idle cycles before the next start bit, so GAP is
  // shortened by two to keep the line high for exactly GAP_CYCLES.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 3);

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [ROM_W-1:0]  rom_q, rom_rd;
  logic [1:0]        pick;
  logic              tx_valid, tx_ready, tx_done;
`ifdef GSM_SCHED_RR_EN
  logic              last_q, last_d;
`endif

  // Script ROM lookup; addresses past the script read as zero.
  always_comb begin
    rom_rd = '0;
    if (addr_q < ROM_AW'(SCRIPT_LEN)) rom_rd = SCRIPT_ROM[addr_q[SCRIPT_IW-1:0]];
  end

  // Arbiter: choose the one-hot winner from the level requests.
  always_comb begin
    pick = req;
`ifdef GSM_SCHED_RR_EN
    if (req == 2'b11) pick = last_q ? 2'b01 : 2'b10;
`else
    if (req[1]) pick = 2'b10;
`endif
  end

  // State, grant, address and gap counter registers plus synchronous ROM read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      gap_q   <= '0;
      rom_q   <= '0;
`ifdef GSM_SCHED_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      rom_q   <= rom_rd;
`ifdef GSM_SCHED_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next-state logic for the script sequencer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    gap_d    = gap_q;
    tx_valid = 1'b0;
`ifdef GSM_SCHED_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          grant_d = pick;
          busy_d  = 1'b1;
          addr_d  = pick[1] ? ROM_AW'(SMS_BASE) : ROM_AW'(CALL_BASE);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) state_d = ST_TXWAIT;
      end
      ST_TXWAIT: begin
        if (tx_done) begin
          if (rom_q[EOS_BIT]) begin
            state_d = ST_FIN;
          end else if (rom_q[EOC_BIT]) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            addr_d  = addr_q + ROM_AW'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          addr_d  = addr_q + ROM_AW'(1);
          state_d = ST_LOAD;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_FIN: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`ifdef GSM_SCHED_RR_EN
        last_d  = grant_q[1];
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (rom_q[BYTE_MSB:0]),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .line_tx  (line_tx)
  );

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = (state_q == ST_FIN) ? grant_q : 2'b00;

endmodule

// File: tb/tb_gsm_cmd_sched.sv
// Directed bench for gsm_cmd_sched with CLKS_PER_BIT=4 and GAP_CYCLES=16.
module tb_gsm_cmd_sched;
  localparam int CPB = 4;
  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] grant, done;
  logic       busy, line_tx;

  int checks = 0;
  int failures = 0;

  logic [7:0] call_b [3] = '{8'h41, 8'h54, 8'h0D};
  logic [7:0] sms_b  [5] = '{8'h41, 8'h54, 8'h0D, 8'h58, 8'h1A};

  gsm_cmd_sched #(.CLKS_PER_BIT(CPB), .GAP_CYCLES(GAP), .ROM_AW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .line_tx (line_tx)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Advance one clock, sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until line_tx goes low; idle = high samples seen first.
  task automatic wait_start(output int idle, output bit ok);
    idle = 0;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (line_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      idle++;
    end
  endtask

  // Called on the first start-bit sample; decodes from bit centres and
  // counts samples that deviate from an ideal 4-cycle-per-bit frame.
  task automatic rx_frame(output logic [7:0] got, output int bad);
    logic s [40];
    logic ideal;
    got = '0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      s[k] = line_tx;
      if (k < 39) step();
    end
    for (int b = 1; b <= 8; b++) got[b-1] = s[b*CPB + 2];
    for (int k = 0; k < 40; k++) begin
      if (k < CPB) ideal = 1'b0;
      else if (k >= 9*CPB) ideal = 1'b1;
      else ideal = got[k/CPB - 1];
      if (s[k] !== ideal) bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b00;
    repeat (3) step();
    checks++;
    if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || line_tx !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: grant=%b done=%b busy=%b line=%b, want 00 00 0 1", grant, done, busy, line_tx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_call();
    int idle, bad;
    bit ok;
    logic [7:0] got;
    req = 2'b01;
    step();
    req = 2'b00;
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL call_grant: grant=%b busy=%b, want 01 1", grant, busy);
    end
    for (int i = 0; i < 3; i++) begin
      wait_start(idle, ok);
      rx_frame(got, bad);
      checks++;
      if (!ok || got !== call_b[i] || bad != 0 || (i > 0 && idle != 2)) begin
        failures++;
        $display("FAIL call_frame%0d: byte=%h bad=%0d idle=%0d start=%0b, want %h 0 2 1", i, got, bad, idle, ok, call_b[i]);
      end
    end
    step();
    checks++;
    if (done !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL call_done: done=%b busy=%b, want 01 1", done, busy);
    end
    step();
    checks++;
    if (done !== 2'b00 || busy !== 1'b0 || grant !== 2'b00 || line_tx !== 1'b1) begin
      failures++;
      $display("FAIL call_release: done=%b busy=%b grant=%b line=%b, want 00 0 00 1", done, busy, grant, line_tx);
    end
  endtask

  task automatic test_sms_gap_regrant();
    int idle, bad, n;
    bit ok;
    logic [7:0] got;
    req = 2'b10;
    step();
    checks++;
    if (grant !== 2'b10) begin
      failures++;
      $display("FAIL sms_grant: grant=%b, want 10", grant);
    end
    for (int i = 0; i < 5; i++) begin
      wait_start(idle, ok);
      rx_frame(got, bad);
      checks++;
      if (!ok || got !== sms_b[i] || bad != 0 || (i > 0 && idle != ((i == 3) ? GAP : 2))) begin
        failures++;
        $display("FAIL sms_frame%0d: byte=%h bad=%0d idle=%0d start=%0b, want %h 0 %0d 1", i, got, bad, idle, ok, sms_b[i], (i == 3) ? GAP : 2);
      end
    end
    step();
    checks++;
    if (done !== 2'b10 || busy !== 1'b1) begin
      failures++;
      $display("FAIL sms_done: done=%b busy=%b, want 10 1", done, busy);
    end
    step();
    checks++;
    if (grant !== 2'b00 || done !== 2'b00) begin
      failures++;
      $display("FAIL sms_idle: grant=%b done=%b, want 00 00", grant, done);
    end
    step();
    checks++;
    if (grant !== 2'b10 || busy !== 1'b1) begin
      failures++;
      $display("FAIL sms_regrant: grant=%b busy=%b, want 10 1", grant, busy);
    end
    req = 2'b00;
    n = 0;
    while (done === 2'b00 && n < 600) begin
      step();
      n++;
    end
    checks++;
    if (done !== 2'b10) begin
      failures++;
      $display("FAIL sms_regrant_done: done=%b after %0d cycles, want 10", done, n);
    end
    step();
  endtask

  task automatic test_simultaneous();
    int n;
    logic [1:0] first, second;
`ifdef GSM_SCHED_RR_EN
    first = 2'b01;
    second = 2'b10;
`else
    first = 2'b10;
    second = 2'b01;
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 2'b11;
    step();
    checks++;
    if (grant !== first) begin
      failures++;
      $display("FAIL both_first: grant=%b, want %b", grant, first);
    end
`ifndef GSM_SCHED_RR_EN
    req = 2'b01;
`endif
    n = 0;
    while (done === 2'b00 && n < 600) begin
      step();
      n++;
    end
    checks++;
    if (done !== first) begin
      failures++;
      $display("FAIL both_first_done: done=%b, want %b", done, first);
    end
    step();
    step();
    checks++;
    if (grant !== second) begin
      failures++;
      $display("FAIL both_second: grant=%b, want %b", grant, second);
    end
    req = 2'b00;
    n = 0;
    while (done === 2'b00 && n < 600) begin
      step();
      n++;
    end
    checks++;
    if (done !== second) begin
      failures++;
      $display("FAIL both_second_done: done=%b, want %b", done, second);
    end
    step();
  endtask

  task automatic test_late_request();
    int idle, bad;
    bit ok;
    logic [7:0] got;
    req = 2'b01;
    step();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL late_grant: grant=%b, want 01", grant);
    end
    for (int i = 0; i < 3; i++) begin
      wait_start(idle, ok);
      rx_frame(got, bad);
      if (i == 0) req = 2'b10;
      checks++;
      if (!ok || got !== call_b[i] || bad != 0 || (i > 0 && idle != 2) || grant !== 2'b01) begin
        failures++;
        $display("FAIL late_frame%0d: byte=%h bad=%0d idle=%0d grant=%b, want %h 0 2 01", i, got, bad, idle, grant, call_b[i]);
      end
    end
    step();
    checks++;
    if (done !== 2'b01) begin
      failures++;
      $display("FAIL late_done: done=%b, want 01", done);
    end
    step();
    checks++;
    if (grant !== 2'b00) begin
      failures++;
      $display("FAIL late_idle: grant=%b, want 00", grant);
    end
    step();
    checks++;
    if (grant !== 2'b10) begin
      failures++;
      $display("FAIL late_sms_grant: grant=%b, want 10", grant);
    end
    req = 2'b00;
    for (int n = 0; n < 600 && done === 2'b00; n++) step();
    checks++;
    if (done !== 2'b10) begin
      failures++;
      $display("FAIL late_sms_done: done=%b, want 10", done);
    end
    step();
  endtask

  task automatic test_mid_reset();
    int idle, bad;
    bit ok;
    logic [7:0] got;
    req = 2'b01;
    step();
    req = 2'b00;
    wait_start(idle, ok);
    rx_frame(got, bad);
    wait_start(idle, ok);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (line_tx !== 1'b1 || grant !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
      failures++;
      $display("FAIL midreset_state: line=%b grant=%b busy=%b done=%b, want 1 00 0 00", line_tx, grant, busy, done);
    end
    repeat (5) step();
    checks++;
    if (line_tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet: line=%b busy=%b, want 1 0", line_tx, busy);
    end
    req = 2'b01;
    step();
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      wait_start(idle, ok);
      rx_frame(got, bad);
      checks++;
      if (!ok || got !== call_b[i] || bad != 0) begin
        failures++;
        $display("FAIL midreset_frame%0d: byte=%h bad=%0d start=%0b, want %h 0 1", i, got, bad, ok, call_b[i]);
      end
    end
    step();
    checks++;
    if (done !== 2'b01) begin
      failures++;
      $display("FAIL midreset_done: done=%b, want 01", done);
    end
    step();
  endtask

  task automatic test_bit_timing();
    int idle, bad, exp_idle;
    bit ok;
    logic [7:0] got;
    req = 2'b01;
    for (int f = 0; f < 100; f++) begin
      wait_start(idle, ok);
      rx_frame(got, bad);
      exp_idle = ((f % 3) == 0) ? 4 : 2;
      checks++;
      if (!ok || got !== call_b[f % 3] || bad != 0 || (f > 0 && idle != exp_idle)) begin
        failures++;
        $display("FAIL timing_frame%0d: byte=%h bad=%0d idle=%0d start=%0b, want %h 0 %0d 1", f, got, bad, idle, ok, call_b[f % 3], exp_idle);
      end
    end
    req = 2'b00;
    for (int n = 0; n < 400 && done === 2'b00; n++) step();
    checks++;
    if (done !== 2'b01) begin
      failures++;
      $display("FAIL timing_done: done=%b, want 01", done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_sms_gap_regrant();
    test_simultaneous();
    test_late_request();
    test_mid_reset();
    test_bit_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
